// File: rtl/input_conditioner_if.sv
// Raw-input / conditioned-strobe bundle for input_conditioner.
// master drives the raw pins and repeat enables; slave is the conditioner.
interface input_conditioner_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] i_raw;
    logic [N_CH-1:0] i_repeat_en;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_press;
    logic [N_CH-1:0] o_release;
    logic [N_CH-1:0] o_long;
    logic [N_CH-1:0] o_repeat;

    modport master (
        output i_raw, i_repeat_en,
        input  o_level, o_press, o_release, o_long, o_repeat
    );

    modport slave (
        input  i_raw, i_repeat_en,
        output o_level, o_press, o_release, o_long, o_repeat
    );
endinterface

// File: rtl/input_conditioner.sv
// N-channel raw-input conditioner: polarity fix, synchroniser, debouncer,
// then press/release edge strobes and long-press / auto-repeat strobes.
module input_conditioner #(
    parameter int              N_CH            = 2,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter int              LONG_CYCLES     = 50000000,
    parameter int              REPEAT_CYCLES   = 10000000,
    parameter logic [N_CH-1:0] INVERT          = '1
) (
    input logic           i_clk,
    input logic           i_rst_p,
    input_conditioner_if.slave bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int RP_W   = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_K   = HOLD_W'(LONG_CYCLES);
    localparam logic [RP_W-1:0]   REP_LAST = RP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONGHELD
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [SYNC_STAGES-1:0] sync_d [N_CH];
    logic [DB_W-1:0]        db_cnt_q [N_CH];
    logic [DB_W-1:0]        db_cnt_d [N_CH];
    logic [HOLD_W-1:0]      hold_q [N_CH];
    logic [HOLD_W-1:0]      hold_d [N_CH];
    logic [RP_W-1:0]        rep_q [N_CH];
    logic [RP_W-1:0]        rep_d [N_CH];
    state_e                 state_q [N_CH];
    state_e                 state_d [N_CH];

    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] level_dly_q, level_dly_d;
    logic [N_CH-1:0] norm, sync_out, press_s, long_s, rep_s;

    assign norm    = bus.i_raw ^ INVERT;
    assign press_s = level_q & ~level_dly_q;

    // Synchroniser and debounce counter
    always_comb begin
        level_dly_d = level_q;
        level_d     = level_q;
        for (int unsigned c = 0; c < N_CH; c++) begin
            sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], norm[c]};
            sync_out[c] = sync_q[c][SYNC_STAGES-1];
            db_cnt_d[c] = '0;
            if (sync_out[c] != level_q[c]) begin
                if (db_cnt_q[c] == DB_LAST) begin
                    level_d[c] = sync_out[c];
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + 1'b1;
                end
            end
        end
    end

    // Hold FSM: hold_q carries the cycle index k (press cycle is k=0) while HELD
    always_comb begin
        long_s = '0;
        rep_s  = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            hold_d[c]  = hold_q[c];
            rep_d[c]   = rep_q[c];
            if (!level_q[c]) begin
                state_d[c] = IDLE;
                hold_d[c]  = '0;
                rep_d[c]   = '0;
            end else begin
                case (state_q[c])
                    IDLE: begin
                        if (press_s[c]) begin
                            state_d[c] = HELD;
                            hold_d[c]  = HOLD_W'(1);
                        end
                    end
                    HELD: begin
                        if (hold_q[c] == LONG_K) begin
                            long_s[c]  = 1'b1;
                            state_d[c] = LONGHELD;
                            hold_d[c]  = '0;
                            rep_d[c]   = '0;
                        end else begin
                            hold_d[c] = hold_q[c] + 1'b1;
                        end
                    end
                    LONGHELD: begin
                        if (!bus.i_repeat_en[c]) begin
                            rep_d[c] = '0;
                        end else if (rep_q[c] == REP_LAST) begin
                            rep_s[c] = 1'b1;
                            rep_d[c] = '0;
                        end else begin
                            rep_d[c] = rep_q[c] + 1'b1;
                        end
                    end
                    default: state_d[c] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_p) begin
            sync_q      <= '{default: '0};
            db_cnt_q    <= '{default: '0};
            hold_q      <= '{default: '0};
            rep_q       <= '{default: '0};
            state_q     <= '{default: IDLE};
            level_q     <= '0;
            level_dly_q <= '0;
        end else begin
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            state_q     <= state_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
        end
    end

    assign bus.o_level   = level_q;
    assign bus.o_press   = press_s;
    assign bus.o_release = ~level_q & level_dly_q;
    assign bus.o_long    = long_s;
    assign bus.o_repeat  = rep_s;
endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a
// history-based behavioural model of the conditioning rules.
module tb_input_conditioner;
    localparam int N = 2, S = 2, D = 4, L = 10, R = 3, HN = 8192;
    localparam logic [1:0] INV = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_conditioner_if #(.N_CH(N)) bus ();

    input_conditioner #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L), .REPEAT_CYCLES(R), .INVERT(INV)
    ) dut (
        .i_clk(clk), .i_rst_p(rst), .bus(bus)
    );

    int checks = 0, passes = 0;
    logic [1:0] inv = INV;

    // Model: full history of normalised samples since reset
    bit hist [N][HN];
    int t = 0;
    bit m_level [N], m_prev [N];
    int m_run [N], m_k [N], m_last_dis [N];

    task automatic model_edge();
        bit seen;
        if (rst) begin
            t = 0;
            for (int c = 0; c < N; c++) begin
                m_level[c] = 0; m_prev[c] = 0; m_run[c] = 0;
                m_k[c] = 0; m_last_dis[c] = -1;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                hist[c][t % HN] = bus.i_raw[c] ^ inv[c];
                seen = (t >= S) ? hist[c][(t - S) % HN] : 1'b0;
                if (m_level[c] && !bus.i_repeat_en[c]) m_last_dis[c] = m_k[c];
                m_prev[c] = m_level[c];
                if (seen != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_level[c] = seen;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (m_level[c] && !m_prev[c]) begin
                    m_k[c] = 0;
                    m_last_dis[c] = -1;
                end else if (m_level[c]) begin
                    m_k[c]++;
                end
            end
            t++;
        end
    endtask

    // {level, press, release, long, repeat} expected in the current cycle
    function automatic logic [4:0] exp_out(int c);
        logic rp = 1'b0;
        int st, len;
        if (m_level[c] && m_k[c] > L && bus.i_repeat_en[c]) begin
            st  = (m_last_dis[c] + 1 > L + 1) ? m_last_dis[c] + 1 : L + 1;
            len = m_k[c] - st + 1;
            rp  = (len > 0) && (len % R == 0);
        end
        return {m_level[c], m_level[c] & ~m_prev[c], ~m_level[c] & m_prev[c],
                m_level[c] && m_k[c] == L, rp};
    endfunction

    function automatic logic [4:0] got_out(int c);
        return {bus.o_level[c], bus.o_press[c], bus.o_release[c], bus.o_long[c], bus.o_repeat[c]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_act(int c, bit act);
        bus.i_raw[c] = act ^ inv[c];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_act(0, 0); set_act(1, 0);
        bus.i_repeat_en = '0;
        repeat (3) tick();
        for (int c = 0; c < N; c++) begin
            checks++;
            if (got_out(c) !== 5'b0) $display("FAIL reset ch%0d got=%b exp=00000", c, got_out(c));
            else passes++;
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int n = 0;
        set_act(0, 1);
        while (n < 20 && !bus.o_level[0]) begin
            tick(); n++;
            checks++;
            if (got_out(0) !== exp_out(0)) $display("FAIL press_model got=%b exp=%b", got_out(0), exp_out(0));
            else passes++;
        end
        checks++;
        if (n !== 6) $display("FAIL press_latency got=%0d exp=6", n); else passes++;
        checks++;
        if (got_out(0) !== 5'b11000) $display("FAIL press_strobe got=%b exp=11000", got_out(0));
        else passes++;
        tick();
        checks++;
        if (got_out(0) !== 5'b10000) $display("FAIL press_once got=%b exp=10000", got_out(0));
        else passes++;
        set_act(0, 0);
        repeat (10) begin
            tick();
            checks++;
            if (got_out(0) !== exp_out(0)) $display("FAIL press_rel got=%b exp=%b", got_out(0), exp_out(0));
            else passes++;
        end
    endtask

    task automatic test_glitch();
        set_act(0, 1);
        repeat (3) tick();
        set_act(0, 0);
        repeat (12) begin
            tick();
            checks++;
            if (got_out(0) !== 5'b0) $display("FAIL glitch got=%b exp=00000", got_out(0));
            else passes++;
        end
    endtask

    task automatic test_long(bit en);
        int n = 0, rels = 0;
        bit late_rep = 0, rel_seen = 0;
        logic [4:0] e;
        bus.i_repeat_en[0] = en;
        set_act(0, 1);
        while (n < 20 && !bus.o_press[0]) begin tick(); n++; end
        checks++;
        if (!bus.o_press[0]) $display("FAIL long_press_timeout got=0 exp=1"); else passes++;
        for (int k = 1; k <= 24; k++) begin
            tick();
            e = {1'b1, 1'b0, 1'b0, k == L, en && k > L && (k - L) % R == 0};
            checks++;
            if (got_out(0) !== e) $display("FAIL long_en%0d k=%0d got=%b exp=%b", en, k, got_out(0), e);
            else passes++;
        end
        set_act(0, 0);
        repeat (15) begin
            tick();
            checks++;
            if (got_out(0) !== exp_out(0)) $display("FAIL long_rel_model got=%b exp=%b", got_out(0), exp_out(0));
            else passes++;
            if (rel_seen && (bus.o_repeat[0] || bus.o_long[0])) late_rep = 1;
            if (bus.o_release[0]) begin rels++; rel_seen = 1; end
        end
        checks++;
        if (rels !== 1 || late_rep) $display("FAIL long_release got=%0d/%0d exp=1/0", rels, late_rep);
        else passes++;
        bus.i_repeat_en[0] = 1'b0;
    endtask

    task automatic test_dual();
        int n = 0;
        set_act(0, 1); set_act(1, 1);
        while (n < 20 && bus.o_level == 2'b00) begin tick(); n++; end
        checks++;
        if (bus.o_level !== 2'b11 || bus.o_press !== 2'b11 || n !== 6)
            $display("FAIL dual got=%b/%b/%0d exp=11/11/6", bus.o_level, bus.o_press, n);
        else passes++;
        set_act(0, 0); set_act(1, 0);
        repeat (10) begin
            tick();
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got_out(c) !== exp_out(c)) $display("FAIL dual_rel ch%0d got=%b exp=%b", c, got_out(c), exp_out(c));
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int n = 0;
        bus.i_repeat_en[0] = 1'b1;
        set_act(0, 1);
        while (n < 20 && !bus.o_press[0]) begin tick(); n++; end
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (got_out(0) !== 5'b0 || got_out(1) !== 5'b0)
            $display("FAIL rst_hold got=%b%b exp=0000000000", got_out(0), got_out(1));
        else passes++;
        n = 0;
        while (n < 20 && !bus.o_press[0]) begin
            tick(); n++;
            checks++;
            if (bus.o_release[0] !== 1'b0) $display("FAIL rst_no_release got=1 exp=0"); else passes++;
        end
        checks++;
        if (n !== 6) $display("FAIL rst_repress got=%0d exp=6", n); else passes++;
        set_act(0, 0);
        bus.i_repeat_en[0] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int left [N];
        bit act [N];
        for (int c = 0; c < N; c++) begin left[c] = 0; act[c] = 0; end
        repeat (1500) begin
            for (int c = 0; c < N; c++) begin
                if (left[c] == 0) begin
                    act[c] = ~act[c];
                    left[c] = $urandom_range(1, 30);
                end
                left[c]--;
                set_act(c, act[c]);
                if ($urandom_range(0, 19) == 0) bus.i_repeat_en[c] = ~bus.i_repeat_en[c];
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got_out(c) !== exp_out(c)) $display("FAIL rand ch%0d got=%b exp=%b", c, got_out(c), exp_out(c));
                else passes++;
                checks++;
                if ($countones(got_out(c) & 5'b01111) > 1) $display("FAIL rand_excl ch%0d got=%b exp=onehot0", c, got_out(c));
                else passes++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.i_raw = INV;
        bus.i_repeat_en = '0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_glitch();
        test_long(1'b1);
        test_long(1'b0);
        test_dual();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised N-channel conditioner for raw board inputs (buttons, switches). It replaces the per-signal sync/debounce/single-pulse chain in top levels. Each channel goes through polarity normalisation, a multi-stage synchroniser and a counter-based debouncer. It then produces a clean level plus one-cycle press, release, long-press and auto-repeat strobes. All channels are independent and run on the system clock ahead of the core and peripheral logic.

Parameters:
N_CH, 2, number of independent channels.
SYNC_STAGES, 2, synchroniser flop depth per channel (must be >= 2).
DEBOUNCE_CYCLES, 500000, consecutive cycles a new input value must persist before it is accepted (>= 2).
LONG_CYCLES, 50000000, cycles a debounced press must be held before o_long fires (>= 1).
REPEAT_CYCLES, 10000000, auto-repeat period once long-press is reached (>= 1).
INVERT, {N_CH{1'b1}}, per-channel mask. 1 = raw pin is active-low.

Ports:
i_clk  in  1  system clock; all logic is on its rising edge.
i_rst_p  in  1  synchronous active-high reset.
i_raw  in  N_CH  asynchronous raw pin inputs.
i_repeat_en  in  N_CH  per-channel auto-repeat enable; synchronous to i_clk.
o_level  out  N_CH  debounced active-high level.
o_press  out  N_CH  1-cycle strobe on debounced rising edge.
o_release  out  N_CH  1-cycle strobe on debounced falling edge.
o_long  out  N_CH  1-cycle strobe when hold time reaches LONG_CYCLES.
o_repeat  out  N_CH  1-cycle strobe every REPEAT_CYCLES after o_long while held and enabled.

Behaviour:
- Normalisation: n[i] = i_raw[i] XOR INVERT[i], so 1 always means "active". This happens before the synchroniser.
- Synchroniser: SYNC_STAGES flops per channel. Reset loads 0 (inactive).
- Debounce: per-channel counter, width $clog2(DEBOUNCE_CYCLES).
  - When sync_out != level: counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync_out still differs: level <= sync_out and counter <= 0.
  - When sync_out == level: counter <= 0. Any shorter glitch therefore leaves the level unchanged.
  - Latency: o_level changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples a stable new raw value.
- Edge strobes (level_d is level delayed one cycle):
  - o_press = level & ~level_d. It is high in the first cycle o_level reads 1.
  - o_release = ~level & level_d.
- Per-channel FSM with states IDLE, HELD, LONGHELD. It uses a hold counter (width $clog2(LONG_CYCLES+1)) and a repeat counter (width $clog2(REPEAT_CYCLES)).
  - IDLE: counters 0. On o_press go to HELD with hold counter = 0. The press cycle is k=0.
  - HELD: hold counter increments each cycle while level=1. At k = LONG_CYCLES, pulse o_long and go to LONGHELD with repeat counter = 0.
  - LONGHELD: if i_repeat_en[i]=1, the repeat counter increments. When it equals REPEAT_CYCLES-1, pulse o_repeat and reset the counter to 0. First repeat is at k = LONG_CYCLES+REPEAT_CYCLES.
  - LONGHELD with i_repeat_en[i]=0: repeat counter held at 0 and no repeats. Re-enabling restarts the period from 0.
  - Release (level=0) in any state: return to IDLE and clear counters. o_release still fires.
  - o_long and o_repeat fire only in cycles where level=1. A release sampled in the same cycle suppresses them.
- Reset (i_rst_p=1 at an edge):
  - All sync flops, levels, level_d, counters and FSMs clear to 0/IDLE. All outputs are 0 from the following cycle.
  - Reset mid-press emits no o_release.
  - If the input is still active after reset deasserts, it is re-detected as a new press after the normal latency.
- Channels never interact. Simultaneous events on several channels each produce their own strobes in the same cycle.
- At most one of o_press, o_release, o_long, o_repeat is high per channel per cycle.

Test Plan:
All scenarios use N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, INVERT=2'b01.
- Clean press: i_raw[0] 1->0 held -> o_level[0] rises 6 edges later, o_press[0]=1 for exactly that cycle, other strobes 0.
- Glitch: i_raw[0] low for 3 cycles, then high -> o_level, o_press and o_release stay 0 throughout.
- Long press with repeat: i_repeat_en[0]=1, hold 25 cycles after press -> o_long[0] at k=10, o_repeat[0] at k=13,16,19,22. Release -> single o_release, no further repeats.
- Long press without repeat: i_repeat_en[0]=0, same hold -> o_long[0] once at k=10, o_repeat[0] never asserted.
- Dual channel: i_raw[0] 1->0 and i_raw[1] 0->1 on the same edge -> both o_level bits and both o_press bits assert in the same cycle.
- Reset mid-hold: i_rst_p pulsed at k=12 while held -> all outputs 0 the next cycle, no o_release. After deassert with the input still active, o_press fires 6 edges later.
